// File: rtl/rom_pipelined.sv
// rtl/rom_pipelined.sv - byte-writable on-chip memory with fixed read latency, in-order responses and sticky write lock
module rom_pipelined #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  input  logic                    lock_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    locked_o
);

  localparam int DEPTH      = 2 ** (ADDR_WIDTH - 2);
  localparam int BE_W       = DATA_WIDTH / 8;
  localparam int OUT_W      = $clog2(READ_LATENCY + 2);
  localparam int FIFO_DEPTH = READ_LATENCY + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W    = DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [OUT_W-1:0]      outstanding;
  logic                  locked_q;
  logic                  accept;
  logic                  rsp_fire;
  logic                  req_err;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [ENTRY_W-1:0]    in_entry;
  logic                  push_valid;
  logic [ENTRY_W-1:0]    push_entry;

  logic [ENTRY_W-1:0]    fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OUT_W-1:0]      fifo_cnt;

  // Credits cover pipeline plus FIFO, so the FIFO can never overflow.
  assign req_ready_o = !rst && (outstanding < OUT_W'(FIFO_DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign word_idx    = req_addr_i[ADDR_WIDTH-1:2];
  assign req_err     = (req_addr_i[1:0] != 2'b00) || (req_we_i && locked_q);
  assign in_entry    = {req_err, (req_err || req_we_i) ? {DATA_WIDTH{1'b0}} : mem[word_idx]};
  assign locked_o    = locked_q;

  always_ff @(posedge clk) begin
    if (accept && req_we_i && !req_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be_i[b]) mem[word_idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q    <= 1'b0;
      outstanding <= '0;
    end else begin
      if (lock_i) locked_q <= 1'b1;
      if (accept && !rsp_fire) outstanding <= outstanding + OUT_W'(1);
      else if (!accept && rsp_fire) outstanding <= outstanding - OUT_W'(1);
    end
  end

  // The FIFO write is the last latency stage, so only READ_LATENCY-1 registers sit in front of it.
  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign push_valid = accept;
      assign push_entry = in_entry;
    end else begin : g_pipe
      logic [READ_LATENCY-2:0] stg_valid;
      logic [ENTRY_W-1:0]      stg_entry [READ_LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          stg_valid <= '0;
        end else begin
          stg_valid[0] <= accept;
          for (int i = 1; i < READ_LATENCY - 1; i++) stg_valid[i] <= stg_valid[i-1];
        end
      end

      always_ff @(posedge clk) begin
        stg_entry[0] <= in_entry;
        for (int i = 1; i < READ_LATENCY - 1; i++) stg_entry[i] <= stg_entry[i-1];
      end

      assign push_valid = stg_valid[READ_LATENCY-2];
      assign push_entry = stg_entry[READ_LATENCY-2];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rsp_valid_o = !rst && (fifo_cnt != '0);
  assign rsp_fire    = rsp_valid_o && rsp_ready_i;
  assign {rsp_err_o, rsp_rdata_o} = rsp_valid_o ? fifo_q[rd_ptr] : {ENTRY_W{1'b0}};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_valid) wr_ptr <= ptr_next(wr_ptr);
      if (rsp_fire) rd_ptr <= ptr_next(rd_ptr);
      if (push_valid && !rsp_fire) fifo_cnt <= fifo_cnt + OUT_W'(1);
      else if (!push_valid && rsp_fire) fifo_cnt <= fifo_cnt - OUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_valid) fifo_q[wr_ptr] <= push_entry;
  end

endmodule
